// File: rtl/par_pkg.sv
// Shared definitions for the serial frame receiver and parity checker.
// Holds the payload width, line idle level and receiver state encoding.
package par_pkg;

  localparam int DATA_W = 3;
  localparam logic IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    MODE,
    STOP,
    BREAK
  } state_t;

endpackage

// File: rtl/par_sync2.sv
// Multi-flop synchronizer for the asynchronous serial line.
// Flops reset to the idle level so reset never looks like a start bit.
module par_sync2 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  import par_pkg::*;

  logic [STAGES-1:0] r_ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff <= {STAGES{IDLE_LVL}};
    end else begin
      r_ff <= {r_ff[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/par_frame_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, mode, stop.
// Presents good frames to the parity checker; flags bad stop bits.
module par_frame_rx #(
  parameter int DATA_W      = par_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              sample_en,
  output logic [DATA_W-1:0] data_out,
  output logic              mode_out,
  output logic              valid,
  output logic              frame_err
);
  import par_pkg::*;

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic w_rx;

  state_t            r_state, w_nx_state;
  logic [CW-1:0]     r_cnt, w_nx_cnt;
  logic [DATA_W-1:0] r_shift, w_nx_shift;
  logic              r_mode, w_nx_mode;
  logic [DATA_W-1:0] r_dout, w_nx_dout;
  logic              r_mout, w_nx_mout;
  logic              r_valid, w_nx_valid;
  logic              r_ferr, w_nx_ferr;

  par_sync2 #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(serial_in),
    .o_q(w_rx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_mode  <= 1'b0;
      r_dout  <= '0;
      r_mout  <= 1'b0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_cnt   <= w_nx_cnt;
      r_shift <= w_nx_shift;
      r_mode  <= w_nx_mode;
      r_dout  <= w_nx_dout;
      r_mout  <= w_nx_mout;
      r_valid <= w_nx_valid;
      r_ferr  <= w_nx_ferr;
    end
  end

  // Pulses clear every cycle; everything else moves only on sample_en.
  always_comb begin
    w_nx_state = r_state;
    w_nx_cnt   = r_cnt;
    w_nx_shift = r_shift;
    w_nx_mode  = r_mode;
    w_nx_dout  = r_dout;
    w_nx_mout  = r_mout;
    w_nx_valid = 1'b0;
    w_nx_ferr  = 1'b0;
    if (sample_en) begin
      unique case (r_state)
        IDLE: begin
          if (!w_rx) begin
            w_nx_state = DATA;
            w_nx_cnt   = '0;
          end
        end
        DATA: begin
          w_nx_shift[r_cnt] = w_rx;
          if (r_cnt == LAST) begin
            w_nx_state = MODE;
            w_nx_cnt   = '0;
          end else begin
            w_nx_cnt = r_cnt + CW'(1);
          end
        end
        MODE: begin
          w_nx_mode  = w_rx;
          w_nx_state = STOP;
        end
        STOP: begin
          if (w_rx) begin
            w_nx_dout  = r_shift;
            w_nx_mout  = r_mode;
            w_nx_valid = 1'b1;
            w_nx_state = IDLE;
          end else begin
            w_nx_ferr  = 1'b1;
            w_nx_state = BREAK;
          end
        end
        BREAK: begin
          if (w_rx) begin
            w_nx_state = IDLE;
          end
        end
        default: begin
          w_nx_state = IDLE;
        end
      endcase
    end
  end

  assign data_out  = r_dout;
  assign mode_out  = r_mout;
  assign valid     = r_valid;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_par_frame_rx.sv
// Directed bench for par_frame_rx.
// Frames are built from data/mode/stop and checked against hand values.
module tb_par_frame_rx;

  localparam int DW = 3;
  localparam int SS = 2;

  logic          clk;
  logic          rst;
  logic          serial_in;
  logic          sample_en;
  logic [DW-1:0] data_out;
  logic          mode_out;
  logic          valid;
  logic          frame_err;

  int total;
  int bad;
  int vcnt;
  int fcnt;

  par_frame_rx #(
    .DATA_W(DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .sample_en(sample_en),
    .data_out(data_out),
    .mode_out(mode_out),
    .valid(valid),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid) vcnt++;
    if (frame_err) fcnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present one bit, let it cross the synchronizer, then strobe it.
  task automatic send_bit(input logic b, input int gap);
    @(negedge clk);
    serial_in = b;
    repeat (SS + 1 + gap) @(negedge clk);
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  // After the stop strobe, v/fe hold the pulse values seen that cycle.
  task automatic send_frame(input logic [DW-1:0] d,
                            input logic m,
                            input logic stp,
                            input int gap,
                            output logic v,
                            output logic fe);
    send_bit(1'b0, gap);
    for (int i = 0; i < DW; i++) send_bit(d[i], gap);
    send_bit(m, gap);
    send_bit(stp, gap);
    v  = valid;
    fe = frame_err;
    @(posedge clk);
    #1;
    chk("pulse_drop", {30'd0, valid, frame_err}, 32'd0);
  endtask

  function automatic logic par_ok(input logic [DW-1:0] d, input logic m);
    return (^d) == m;
  endfunction

  logic v, fe;
  int   v0, f0;

  initial begin
    total = 0;
    bad = 0;
    vcnt = 0;
    fcnt = 0;
    serial_in = 1'b1;
    sample_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_mode", 32'(mode_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // good frame 101 / odd
    v0 = vcnt;
    send_frame(3'b101, 1'b1, 1'b1, 0, v, fe);
    chk("g1_valid", 32'(v), 32'd1);
    chk("g1_ferr", 32'(fe), 32'd0);
    chk("g1_data", 32'(data_out), 32'h5);
    chk("g1_mode", 32'(mode_out), 32'd1);
    chk("g1_vcnt", 32'(vcnt - v0), 32'd1);

    // bad stop bit, then held-low line in BREAK
    v0 = vcnt;
    f0 = fcnt;
    send_frame(3'b011, 1'b0, 1'b0, 0, v, fe);
    chk("e_ferr", 32'(fe), 32'd1);
    chk("e_valid", 32'(v), 32'd0);
    chk("e_data", 32'(data_out), 32'h5);
    chk("e_mode", 32'(mode_out), 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
    chk("brk_vcnt", 32'(vcnt - v0), 32'd0);
    chk("brk_fcnt", 32'(fcnt - f0), 32'd1);
    send_bit(1'b1, 0);
    send_frame(3'b100, 1'b0, 1'b1, 0, v, fe);
    chk("g2_valid", 32'(v), 32'd1);
    chk("g2_data", 32'(data_out), 32'h4);
    chk("g2_mode", 32'(mode_out), 32'd0);

    // back-to-back frames, no idle bit between
    v0 = vcnt;
    send_frame(3'b011, 1'b0, 1'b1, 0, v, fe);
    chk("b1_valid", 32'(v), 32'd1);
    chk("b1_data", 32'(data_out), 32'h3);
    chk("b1_mode", 32'(mode_out), 32'd0);
    send_frame(3'b110, 1'b1, 1'b1, 0, v, fe);
    chk("b2_valid", 32'(v), 32'd1);
    chk("b2_data", 32'(data_out), 32'h6);
    chk("b2_mode", 32'(mode_out), 32'd1);
    chk("bb_vcnt", 32'(vcnt - v0), 32'd2);
    chk("par_110_odd", 32'(par_ok(data_out, mode_out)), 32'd0);

    // reset after the second data bit
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_data", 32'(data_out), 32'd0);
    chk("mr_mode", 32'(mode_out), 32'd0);
    chk("mr_valid", 32'(valid), 32'd0);
    serial_in = 1'b0;
    repeat (2) @(negedge clk);
    sample_en = 1'b1;
    repeat (3) @(negedge clk);
    sample_en = 1'b0;
    serial_in = 1'b1;
    rst = 1'b0;
    v0 = vcnt;
    f0 = fcnt;
    for (int i = 0; i < 6; i++) send_bit(1'b1, 0);
    chk("mr_idle_v", 32'(vcnt - v0), 32'd0);
    chk("mr_idle_f", 32'(fcnt - f0), 32'd0);
    send_frame(3'b111, 1'b1, 1'b1, 0, v, fe);
    chk("mr_valid2", 32'(v), 32'd1);
    chk("mr_data2", 32'(data_out), 32'h7);
    chk("mr_vcnt", 32'(vcnt - v0), 32'd1);
    chk("par_111_odd", 32'(par_ok(data_out, mode_out)), 32'd1);

    // sample_en gaps of 10 cycles between bits
    v0 = vcnt;
    send_frame(3'b010, 1'b0, 1'b1, 10, v, fe);
    chk("gap_valid", 32'(v), 32'd1);
    chk("gap_data", 32'(data_out), 32'h2);
    chk("gap_mode", 32'(mode_out), 32'd0);
    chk("gap_vcnt", 32'(vcnt - v0), 32'd1);

    // idle line with strobes on consecutive cycles
    v0 = vcnt;
    f0 = fcnt;
    @(negedge clk);
    serial_in = 1'b1;
    sample_en = 1'b1;
    repeat (20) @(negedge clk);
    sample_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_vcnt", 32'(vcnt - v0), 32'd0);
    chk("idle_fcnt", 32'(fcnt - f0), 32'd0);
    chk("idle_data", 32'(data_out), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
